// File: rtl/alu_pkg.sv
// Shared constants, itype bit positions and FSM encoding for the ALU issue front end.
`default_nettype none

package alu_pkg;

  localparam logic [6:0] OP_OP   = 7'h33;
  localparam logic [6:0] OP_IMM  = 7'h13;

  localparam int IT_R = 5;
  localparam int IT_I = 4;
  localparam int IT_S = 3;
  localparam int IT_B = 2;
  localparam int IT_U = 1;
  localparam int IT_J = 0;

  localparam logic [6:0] F7_ZERO = 7'h00;
  localparam logic [6:0] F7_ALT  = 7'h20;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_WB   = 2'd2
  } state_e;

endpackage

`default_nettype wire

// File: rtl/alu_issue_if.sv
// Instruction-in, ALU-operand and writeback signals of the issue block.
`default_nettype none

interface alu_issue_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [31:0]      in_instr;
  logic [WIDTH-1:0] in_rs1_val;
  logic [WIDTH-1:0] in_rs2_val;

  logic [9:0]       alu_fun;
  logic [5:0]       alu_itype;
  logic [WIDTH-1:0] alu_in1;
  logic [WIDTH-1:0] alu_in2;
  logic [WIDTH-1:0] alu_out;

  logic             wb_valid;
  logic             wb_ready;
  logic [4:0]       wb_rd;
  logic [WIDTH-1:0] wb_data;
  logic             wb_illegal;

  // Design-side view.
  modport slave (
    input  in_valid, in_instr, in_rs1_val, in_rs2_val, alu_out, wb_ready,
    output in_ready, alu_fun, alu_itype, alu_in1, alu_in2,
           wb_valid, wb_rd, wb_data, wb_illegal
  );

  // Environment-side view (register read, ALU, register-file writer).
  modport master (
    output in_valid, in_instr, in_rs1_val, in_rs2_val, alu_out, wb_ready,
    input  in_ready, alu_fun, alu_itype, alu_in1, alu_in2,
           wb_valid, wb_rd, wb_data, wb_illegal
  );
endinterface

`default_nettype wire

// File: rtl/alu_decode.sv
// Combinational RV32I OP / OP-IMM decoder producing ALU function, type and immediate.
`default_nettype none

module alu_decode
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [31:0]      instr_i,
  output logic [9:0]       fun_o,
  output logic [5:0]       itype_o,
  output logic [WIDTH-1:0] imm_sext_o,
  output logic [4:0]       rd_o,
  output logic             illegal_o
);

  logic [6:0] w_opcode;
  logic [2:0] w_f3;
  logic [6:0] w_f7;
  logic       w_unused_rs1;

  assign w_opcode     = instr_i[6:0];
  assign w_f3         = instr_i[14:12];
  assign w_f7         = instr_i[31:25];
  assign w_unused_rs1 = ^instr_i[19:15];

  assign rd_o       = instr_i[11:7];
  assign imm_sext_o = {{(WIDTH-12){instr_i[31]}}, instr_i[31:20]};

  always_comb begin
    fun_o     = '0;
    itype_o   = '0;
    illegal_o = 1'b1;
    if (w_opcode == OP_OP) begin
      fun_o         = {w_f3, w_f7};
      itype_o[IT_R] = 1'b1;
      illegal_o     = !((w_f7 == F7_ZERO) ||
                        ((w_f7 == F7_ALT) && ((w_f3 == 3'd0) || (w_f3 == 3'd5))));
    end else if (w_opcode == OP_IMM) begin
      // funct7 is zeroed; SRAI is recognised by the ALU from imm[11:5] in operand 2.
      fun_o         = {w_f3, 7'h00};
      itype_o[IT_I] = 1'b1;
      case (w_f3)
        3'd1:    illegal_o = (w_f7 != F7_ZERO);
        3'd5:    illegal_o = !((w_f7 == F7_ZERO) || (w_f7 == F7_ALT));
        default: illegal_o = 1'b0;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: rtl/alu_issue.sv
// Issue sequencer: accept one instruction, drive the ALU for one cycle, present the writeback beat.
`default_nettype none

module alu_issue
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic        clk,
  input  logic        rst,
  alu_issue_if.slave  bus
);

  logic [9:0]       dec_fun;
  logic [5:0]       dec_itype;
  logic [WIDTH-1:0] dec_imm;
  logic [4:0]       dec_rd;
  logic             dec_illegal;

  alu_decode #(.WIDTH(WIDTH)) u_decode (
    .instr_i    (bus.in_instr),
    .fun_o      (dec_fun),
    .itype_o    (dec_itype),
    .imm_sext_o (dec_imm),
    .rd_o       (dec_rd),
    .illegal_o  (dec_illegal)
  );

  state_e           state_q,   state_d;
  logic [9:0]       fun_q,     fun_d;
  logic [5:0]       itype_q,   itype_d;
  logic [WIDTH-1:0] in1_q,     in1_d;
  logic [WIDTH-1:0] in2_q,     in2_d;
  logic [4:0]       rd_q,      rd_d;
  logic [WIDTH-1:0] data_q,    data_d;
  logic             illegal_q, illegal_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      fun_q     <= '0;
      itype_q   <= '0;
      in1_q     <= '0;
      in2_q     <= '0;
      rd_q      <= '0;
      data_q    <= '0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      fun_q     <= fun_d;
      itype_q   <= itype_d;
      in1_q     <= in1_d;
      in2_q     <= in2_d;
      rd_q      <= rd_d;
      data_q    <= data_d;
      illegal_q <= illegal_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    fun_d     = fun_q;
    itype_d   = itype_q;
    in1_d     = in1_q;
    in2_d     = in2_q;
    rd_d      = rd_q;
    data_d    = data_q;
    illegal_d = illegal_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.in_valid) begin
          rd_d      = dec_rd;
          illegal_d = dec_illegal;
          if (dec_illegal) begin
            // ALU operands are left untouched; the beat skips EXEC.
            data_d  = '0;
            state_d = ST_WB;
          end else begin
            fun_d   = dec_fun;
            itype_d = dec_itype;
            in1_d   = bus.in_rs1_val;
            in2_d   = dec_itype[IT_R] ? bus.in_rs2_val : dec_imm;
            state_d = ST_EXEC;
          end
        end
      end
      ST_EXEC: begin
        data_d  = (rd_q == 5'd0) ? '0 : bus.alu_out;
        state_d = ST_WB;
      end
      ST_WB: begin
        if (bus.wb_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign bus.in_ready   = (state_q == ST_IDLE);
  assign bus.alu_fun    = fun_q;
  assign bus.alu_itype  = itype_q;
  assign bus.alu_in1    = in1_q;
  assign bus.alu_in2    = in2_q;
  assign bus.wb_valid   = (state_q == ST_WB);
  assign bus.wb_rd      = rd_q;
  assign bus.wb_data    = data_q;
  assign bus.wb_illegal = illegal_q;

endmodule

`default_nettype wire

// File: tb/tb_alu_issue.sv
// Directed scoreboard bench for alu_issue with a behavioural RV32I ALU on the operand port.
`default_nettype none

module tb_alu_issue;

  logic clk;
  logic rst;
  int   total = 0;
  int   bad   = 0;

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] data;
    logic        ill;
  } wb_t;

  wb_t sb[$];

  alu_issue_if #(.WIDTH(32)) bus ();

  alu_issue #(.WIDTH(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural ALU: R-type uses funct7 bit5, I-type uses imm bit10 (operand 2) for SUB/SRA.
  function automatic logic [31:0] alu_model(logic [9:0] fun, logic [5:0] it,
                                            logic [31:0] a, logic [31:0] b);
    logic [2:0]  f3;
    logic        alt;
    logic [31:0] r;
    f3  = fun[9:7];
    alt = it[5] ? fun[5] : b[10];
    case (f3)
      3'd0:    r = (it[5] && alt) ? a - b : a + b;
      3'd1:    r = a << b[4:0];
      3'd2:    r = {31'b0, $signed(a) < $signed(b)};
      3'd3:    r = {31'b0, a < b};
      3'd4:    r = a ^ b;
      3'd5:    r = alt ? $unsigned($signed(a) >>> b[4:0]) : a >> b[4:0];
      3'd6:    r = a | b;
      default: r = a & b;
    endcase
    return r;
  endfunction

  always_comb bus.alu_out = alu_model(bus.alu_fun, bus.alu_itype, bus.alu_in1, bus.alu_in2);

  // Reference writeback result computed straight from the instruction semantics.
  function automatic wb_t ref_wb(logic [31:0] ins, logic [31:0] a, logic [31:0] b);
    wb_t         w;
    logic [6:0]  op;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [31:0] opb;
    logic [31:0] res;
    logic        legal;
    op    = ins[6:0];
    f3    = ins[14:12];
    f7    = ins[31:25];
    legal = 1'b0;
    if (op == 7'h33)
      legal = (f7 == 7'h00) || ((f7 == 7'h20) && (f3 == 3'd0 || f3 == 3'd5));
    else if (op == 7'h13)
      legal = (f3 == 3'd1) ? (f7 == 7'h00) :
              (f3 == 3'd5) ? (f7 == 7'h00 || f7 == 7'h20) : 1'b1;
    opb = (op == 7'h33) ? b : {{20{ins[31]}}, ins[31:20]};
    case (f3)
      3'd0:    res = (op == 7'h33 && f7 == 7'h20) ? a - opb : a + opb;
      3'd1:    res = a << opb[4:0];
      3'd2:    res = ($signed(a) < $signed(opb)) ? 32'd1 : 32'd0;
      3'd3:    res = (a < opb) ? 32'd1 : 32'd0;
      3'd4:    res = a ^ opb;
      3'd5:    res = (f7 == 7'h20) ? $unsigned($signed(a) >>> opb[4:0]) : a >> opb[4:0];
      3'd6:    res = a | opb;
      default: res = a & opb;
    endcase
    w.rd   = ins[11:7];
    w.ill  = !legal;
    w.data = (!legal || ins[11:7] == 5'd0) ? 32'd0 : res;
    return w;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_in_ready"},   32'(bus.in_ready),   32'd1);
    chk({tag, "_wb_valid"},   32'(bus.wb_valid),   32'd0);
    chk({tag, "_wb_illegal"}, 32'(bus.wb_illegal), 32'd0);
    chk({tag, "_wb_rd"},      32'(bus.wb_rd),      32'd0);
    chk({tag, "_wb_data"},    bus.wb_data,         32'd0);
    chk({tag, "_alu_fun"},    32'(bus.alu_fun),    32'd0);
    chk({tag, "_alu_itype"},  32'(bus.alu_itype),  32'd0);
    chk({tag, "_alu_in1"},    bus.alu_in1,         32'd0);
    chk({tag, "_alu_in2"},    bus.alu_in2,         32'd0);
  endtask

  // Drive one beat; returns #1 after the accepting edge.
  task automatic issue(input logic [31:0] ins, input logic [31:0] a, input logic [31:0] b);
    int n;
    n = 0;
    while (!bus.in_ready && n < 20) begin
      tick();
      n++;
    end
    chk("in_ready_wait", 32'(bus.in_ready), 32'd1);
    bus.in_instr   = ins;
    bus.in_rs1_val = a;
    bus.in_rs2_val = b;
    bus.in_valid   = 1'b1;
    sb.push_back(ref_wb(ins, a, b));
    tick();
    bus.in_valid   = 1'b0;
  endtask

  // Expects a writeback beat this cycle, compares against the scoreboard head and retires it.
  task automatic take(input string tag);
    wb_t e;
    chk({tag, "_wb_valid"}, 32'(bus.wb_valid), 32'd1);
    chk({tag, "_sb_nonempty"}, 32'(sb.size() != 0), 32'd1);
    if (sb.size() != 0) begin
      e = sb.pop_front();
      chk({tag, "_wb_rd"},      32'(bus.wb_rd),      32'(e.rd));
      chk({tag, "_wb_data"},    bus.wb_data,         e.data);
      chk({tag, "_wb_illegal"}, 32'(bus.wb_illegal), 32'(e.ill));
    end
    bus.wb_ready = 1'b1;
    tick();
    bus.wb_ready = 1'b0;
    chk({tag, "_in_ready_after"}, 32'(bus.in_ready), 32'd1);
    chk({tag, "_wb_valid_after"}, 32'(bus.wb_valid), 32'd0);
  endtask

  initial begin
    logic [31:0] tbl_ins [4];
    logic [31:0] tbl_a   [4];
    logic [31:0] tbl_b   [4];
    logic [31:0] ill_ins [4];
    wb_t         hold;

    rst            = 1'b1;
    bus.in_valid   = 1'b0;
    bus.in_instr   = '0;
    bus.in_rs1_val = '0;
    bus.in_rs2_val = '0;
    bus.wb_ready   = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    tick();
    chk_reset_state("reset");

    // add x3,x1,x2
    issue(32'h002081B3, 32'd5, 32'd7);
    chk("add_alu_fun",   32'(bus.alu_fun),   32'h000);
    chk("add_alu_itype", 32'(bus.alu_itype), 32'h20);
    chk("add_alu_in1",   bus.alu_in1,        32'd5);
    chk("add_alu_in2",   bus.alu_in2,        32'd7);
    chk("add_exec_wb_valid", 32'(bus.wb_valid), 32'd0);
    chk("add_exec_in_ready", 32'(bus.in_ready), 32'd0);
    tick();
    chk("add_wb_data_12", bus.wb_data, 32'd12);
    take("add");

    // srai x1,x1,4
    issue(32'h4040D093, 32'h8000_0000, 32'h1234_5678);
    chk("srai_alu_fun",   32'(bus.alu_fun),   32'h280);
    chk("srai_alu_itype", 32'(bus.alu_itype), 32'h10);
    chk("srai_alu_in2",   bus.alu_in2,        32'h404);
    tick();
    chk("srai_wb_data",      bus.wb_data,      32'hF800_0000);
    chk("srai_alu_fun_hold", 32'(bus.alu_fun), 32'h280);
    take("srai");

    // addi x1,x2,-1
    issue(32'hFFF10093, 32'd10, 32'hDEAD_BEEF);
    chk("addi_alu_in2", bus.alu_in2, 32'hFFFF_FFFF);
    tick();
    take("addi");

    // slt, sltu, slli 31, andi
    tbl_ins = '{32'h0020A1B3, 32'h0020B1B3, 32'h01F09093, 32'h0F02F213};
    tbl_a   = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd3, 32'h1234_5678};
    tbl_b   = '{32'd1, 32'd1, 32'd0, 32'd0};
    for (int i = 0; i < 4; i++) begin
      issue(tbl_ins[i], tbl_a[i], tbl_b[i]);
      tick();
      take($sformatf("op%0d", i));
    end

    // jal, xor with funct7 0x20, bad opcode[1:0], slli with nonzero imm[11:5]
    ill_ins = '{32'h0000006F, 32'h4020C1B3, 32'h002081B1, 32'h02009093};
    for (int i = 0; i < 4; i++) begin
      issue(ill_ins[i], 32'd9, 32'd9);
      take($sformatf("illegal%0d", i));
    end

    // Backpressure: sub x5,x6,x7 held in WB for 5 cycles.
    issue(32'h407302B3, 32'd3, 32'd10);
    tick();
    hold = sb[0];
    for (int i = 0; i < 5; i++) begin
      chk("bp_wb_valid", 32'(bus.wb_valid), 32'd1);
      chk("bp_in_ready", 32'(bus.in_ready), 32'd0);
      chk("bp_wb_rd",    32'(bus.wb_rd),    32'(hold.rd));
      chk("bp_wb_data",  bus.wb_data,       hold.data);
      tick();
    end
    chk("bp_sub_value", bus.wb_data, 32'hFFFF_FFF9);
    take("bp");

    // Reset while in EXEC drops the beat.
    issue(32'h002081B3, 32'd1, 32'd2);
    chk("rstexec_in_ready", 32'(bus.in_ready), 32'd0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk_reset_state("rst_exec");
    sb.delete();

    // add x0,x1,x2: result discarded.
    issue(32'h00208033, 32'd1, 32'd1);
    chk("x0_alu_in1", bus.alu_in1, 32'd1);
    tick();
    take("addx0");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire
